// File: rtl/mram_pkg.sv
// ============================================================================
//  Module      : mram_pkg
//  Description : Shared encodings, FSM states and default widths for the MRAM
//                access arbiter and its serialiser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mram_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 8;

    localparam logic [2:0] RWS_IDLE  = 3'b000;
    localparam logic [2:0] RWS_WRITE = 3'b001;
    localparam logic [2:0] RWS_READ  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SH_ADDR = 3'd1,
        ST_SH_LEN  = 3'd2,
        ST_SH_DATA = 3'd3,
        ST_EXEC    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mram_piso_shifter.sv
// ============================================================================
//  Module      : mram_piso_shifter
//  Description : Loadable MSB-first shift register with remaining-bit counter
//                and last-bit flag; reloaded once per serial phase.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mram_piso_shifter
    import mram_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_nbits,
    input  logic             i_shift,
    output logic             o_bit,
    output logic             o_last
);

    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;

    // A load in the same cycle as a shift wins: the outgoing bit has already
    // been consumed by the caller at this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
            r_cnt  <= i_nbits;
        end else if (i_shift) begin
            r_sreg <= r_sreg << 1;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_bit  = r_sreg[WIDTH-1];
    assign o_last = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mram_access_arbiter.sv
// ============================================================================
//  Module      : mram_access_arbiter
//  Description : Two-port round-robin arbiter that serialises the granted MRAM
//                command and sequences the access window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mram_access_arbiter
    import mram_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int LEN_W         = DEF_LEN_W,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [LEN_W-1:0]  req0_len,
    input  logic              req0_wr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [LEN_W-1:0]  req1_len,
    input  logic              req1_wr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              burst_en,
    output logic              mode_sel,
    output logic              burst_len_ser,
    output logic              addr_ser,
    output logic              data_ser,
    output logic [2:0]        read_write_sel,
    output logic              busy,
    output logic              done,
    output logic              done_id
);

    localparam int c_SH_W   = max3(ADDR_W, DATA_W, LEN_W);
    localparam int c_SH_CW  = $clog2(c_SH_W + 1);
    localparam int c_EXEC_W = LEN_W + $clog2(ACCESS_CYCLES) + 1;
    localparam logic [c_EXEC_W-1:0] c_AC  = c_EXEC_W'(ACCESS_CYCLES);
    localparam logic [c_EXEC_W-1:0] c_ONE = c_EXEC_W'(1);

    state_t r_state, w_next, w_after_addr, w_follow;

    logic               r_last_grant, r_grant_id;
    logic [LEN_W-1:0]   r_len;
    logic               r_wr, r_mode;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_phase_last;
    logic [c_EXEC_W-1:0] r_exec_cnt;

    logic       r_req0_ready, r_req1_ready, r_burst_en, r_mode_sel;
    logic       r_len_ser, r_addr_ser, r_data_ser, r_busy, r_done, r_done_id;
    logic [2:0] r_rws;

    logic               w_granted, w_grant, w_pick, w_consume, w_in_cmd;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [LEN_W-1:0]   w_sel_len;
    logic               w_sel_wr, w_sel_mode;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [c_EXEC_W-1:0] w_exec_load;

    logic               w_sh_load, w_sh_bit, w_sh_last;
    logic [c_SH_W-1:0]  w_sh_data;
    logic [c_SH_CW-1:0] w_sh_nbits;

    // The cycle carrying the ready pulse is still IDLE; it only launches SH_ADDR.
    assign w_granted = r_req0_ready | r_req1_ready;
    assign w_grant   = (r_state == ST_IDLE) && !w_granted && (req0_valid || req1_valid);
    assign w_pick    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    assign w_sel_addr  = w_pick ? req1_addr  : req0_addr;
    assign w_sel_len   = w_pick ? req1_len   : req0_len;
    assign w_sel_wr    = w_pick ? req1_wr    : req0_wr;
    assign w_sel_wdata = w_pick ? req1_wdata : req0_wdata;
    assign w_sel_mode  = (w_sel_len != '0) && !w_sel_wr;

    assign w_after_addr = r_mode ? ST_SH_LEN : (r_wr ? ST_SH_DATA : ST_EXEC);
    assign w_exec_load  = r_mode ? (c_AC * (c_EXEC_W'(r_len) + c_ONE) - c_ONE)
                                 : (c_AC - c_ONE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_granted)          w_next = ST_SH_ADDR;
            ST_SH_ADDR: if (r_phase_last)       w_next = w_after_addr;
            ST_SH_LEN:  if (r_phase_last)       w_next = r_wr ? ST_SH_DATA : ST_EXEC;
            ST_SH_DATA: if (r_phase_last)       w_next = ST_EXEC;
            ST_EXEC:    if (r_exec_cnt == '0)   w_next = ST_DONE;
            ST_DONE:                            w_next = ST_IDLE;
            default:                            w_next = ST_IDLE;
        endcase
    end

    // The shifter runs one bit ahead of the registered serial outputs, so the
    // next phase is loaded on the edge that consumes the current phase's last bit.
    always_comb begin
        w_consume = (w_next == ST_SH_ADDR) || (w_next == ST_SH_LEN) || (w_next == ST_SH_DATA);
        w_in_cmd  = w_consume || (w_next == ST_EXEC);
        unique case (w_next)
            ST_SH_ADDR: w_follow = w_after_addr;
            ST_SH_LEN:  w_follow = r_wr ? ST_SH_DATA : ST_EXEC;
            default:    w_follow = ST_EXEC;
        endcase
        w_sh_load  = 1'b0;
        w_sh_data  = '0;
        w_sh_nbits = '0;
        if (w_grant) begin
            w_sh_load  = 1'b1;
            w_sh_data  = c_SH_W'(w_sel_addr) << (c_SH_W - ADDR_W);
            w_sh_nbits = c_SH_CW'(ADDR_W);
        end else if (w_consume && w_sh_last) begin
            if (w_follow == ST_SH_LEN) begin
                w_sh_load  = 1'b1;
                w_sh_data  = c_SH_W'(r_len) << (c_SH_W - LEN_W);
                w_sh_nbits = c_SH_CW'(LEN_W);
            end else if (w_follow == ST_SH_DATA) begin
                w_sh_load  = 1'b1;
                w_sh_data  = c_SH_W'(r_wdata) << (c_SH_W - DATA_W);
                w_sh_nbits = c_SH_CW'(DATA_W);
            end
        end
    end

    mram_piso_shifter #(
        .WIDTH (c_SH_W),
        .CNT_W (c_SH_CW)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_sh_load),
        .i_data  (w_sh_data),
        .i_nbits (w_sh_nbits),
        .i_shift (w_consume),
        .o_bit   (w_sh_bit),
        .o_last  (w_sh_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_len        <= '0;
            r_wr         <= 1'b0;
            r_mode       <= 1'b0;
            r_wdata      <= '0;
            r_phase_last <= 1'b0;
            r_exec_cnt   <= '0;
            r_req0_ready <= 1'b0;
            r_req1_ready <= 1'b0;
            r_burst_en   <= 1'b0;
            r_mode_sel   <= 1'b0;
            r_len_ser    <= 1'b0;
            r_addr_ser   <= 1'b0;
            r_data_ser   <= 1'b0;
            r_rws        <= RWS_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_id    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_last_grant <= w_pick;
                r_grant_id   <= w_pick;
                r_len        <= w_sel_len;
                r_wr         <= w_sel_wr;
                r_mode       <= w_sel_mode;
                r_wdata      <= w_sel_wdata;
            end
            r_phase_last <= w_consume && w_sh_last;
            if ((w_next == ST_EXEC) && (r_state != ST_EXEC)) begin
                r_exec_cnt <= w_exec_load;
            end else if ((r_state == ST_EXEC) && (r_exec_cnt != '0)) begin
                r_exec_cnt <= r_exec_cnt - c_ONE;
            end
            r_req0_ready <= w_grant && !w_pick;
            r_req1_ready <= w_grant && w_pick;
            r_busy       <= w_grant || (w_next != ST_IDLE);
            r_burst_en   <= w_in_cmd;
            r_mode_sel   <= w_in_cmd && r_mode;
            r_addr_ser   <= (w_next == ST_SH_ADDR) && w_sh_bit;
            r_len_ser    <= (w_next == ST_SH_LEN)  && w_sh_bit;
            r_data_ser   <= (w_next == ST_SH_DATA) && w_sh_bit;
            r_rws        <= (w_next == ST_EXEC) ? (r_wr ? RWS_WRITE : RWS_READ) : RWS_IDLE;
            r_done       <= (w_next == ST_DONE);
            r_done_id    <= (w_next == ST_DONE) && r_grant_id;
        end
    end

    assign req0_ready     = r_req0_ready;
    assign req1_ready     = r_req1_ready;
    assign burst_en       = r_burst_en;
    assign mode_sel       = r_mode_sel;
    assign burst_len_ser  = r_len_ser;
    assign addr_ser       = r_addr_ser;
    assign data_ser       = r_data_ser;
    assign read_write_sel = r_rws;
    assign busy           = r_busy;
    assign done           = r_done;
    assign done_id        = r_done_id;

endmodule

`default_nettype wire

// File: doc/mram_access_arbiter.md
# mram_access_arbiter

Two-port round-robin arbiter and command sequencer that sits in front of the MRAM integration top level. It accepts parallel access requests (address, burst length, direction, write word) from two requesters. It grants one request at a time and serialises the granted command onto the serial address, burst-length and data lines. It then drives the burst-control and read/write-select inputs for the access window and reports completion to the winning requester.

## Interface
Parameters
- ADDR_W, 20, MRAM word-address width; serial address length
- DATA_W, 16, MRAM data width; serial write-data length
- LEN_W, 8, burst-length field width; serial burst-length length
- ACCESS_CYCLES, 4, cycles the controller is given per MRAM word

Ports
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- reqN_valid  in  1  (N = 0,1) request pending; held with fields stable until reqN_ready
- reqN_ready  out  1  one-cycle accept pulse
- reqN_addr  in  ADDR_W  start address
- reqN_len  in  LEN_W  extra words after the first; 0 = single transfer
- reqN_wr  in  1  1 = write, 0 = read
- reqN_wdata  in  DATA_W  write word (ignored for reads)
- burst_en  out  1  enables burst controller during a command
- mode_sel  out  1  0 = single transfer, 1 = burst
- burst_len_ser  out  1  serial burst length, MSB first
- addr_ser  out  1  serial start address, MSB first
- data_ser  out  1  serial write data, MSB first
- read_write_sel  out  3  3'b000 idle, 3'b001 write, 3'b010 read; other codes never driven
- busy  out  1  high from grant through DONE
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester index of completed command; valid with done

## Operation
- FSM: IDLE, SH_ADDR, SH_LEN, SH_DATA, EXEC, DONE.
- IDLE
  - If any reqN_valid: arbitrate, pulse reqN_ready, capture fields, and go to SH_ADDR next cycle.
- Round-robin arbitration
  - Register last_grant, reset value 1, so req0 wins the first contest.
  - Both valid: grant !last_grant. Single valid: grant it.
  - last_grant updates on grant.
- Effective mode: mode_sel = (len != 0) && !wr. Writes are always single transfer; len is ignored for writes.
- SH_ADDR: ADDR_W cycles, addr_ser = addr[ADDR_W-1-i] on phase cycle i.
- SH_LEN: LEN_W cycles, burst_len_ser = len MSB first. Skipped when mode_sel = 0.
- SH_DATA: DATA_W cycles, data_ser = wdata MSB first. Skipped for reads.
- EXEC
  - read_write_sel = write/read code.
  - Duration: ACCESS_CYCLES × (len+1) cycles for burst reads, ACCESS_CYCLES otherwise.
  - Counter width: LEN_W + clog2(ACCESS_CYCLES) + 1.
- DONE: done = 1 and done_id = grant for one cycle, then IDLE. A new grant is possible in the following IDLE cycle.
- burst_en and mode_sel are held constant from SH_ADDR through EXEC.
- Serial lines are 0 outside their own phase.
- Requests arriving while busy wait; reqN_ready never pulses outside IDLE.
- Reset (any state)
  - Asynchronous return to IDLE; captured command discarded; no done.
  - All outputs 0, read_write_sel = 3'b000, last_grant = 1.

## Timing
- Grant at IDLE cycle T: reqN_ready high in T, first address bit in T+1.
- Single read: 1 + 20 + 4 + 1 = 26 cycles from grant to end of DONE. done is in cycle T+25.
- Single write: 1 + 20 + 16 + 4 + 1 = 42 cycles.
- Burst read, len L: 1 + 20 + 8 + 4(L+1) + 1 cycles.
- Back-to-back: minimum one IDLE cycle between DONE and the next reqN_ready.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package mram_pkg holds:
  - read_write_sel codes RWS_IDLE/RWS_WRITE/RWS_READ
  - FSM state enum
  - default widths ADDR_W/DATA_W/LEN_W
- One sub-module: mram_piso_shifter. It is a parameterised width loadable MSB-first shift register with a bit counter and a last-bit flag, instantiated once and reloaded per phase.

## Test plan
- req0 read addr 20'hABCDE, len 0 -> mode_sel 0; addr_ser shows 1010_1011_1100_1101_1110 over cycles T+1..T+20; read_write_sel 3'b010 for 4 cycles; done with done_id 0 at T+25.
- req1 write addr 20'h00001, wdata 16'hA5A5, len 5 -> mode_sel 0, no SH_LEN; data_ser shows A5A5; read_write_sel 3'b001 for 4 cycles; done_id 1 at T+41.
- req0 burst read len 8'd3 -> mode_sel 1; burst_len_ser shows 0000_0011; EXEC lasts 16 cycles.
- Both valid continuously for 4 commands from reset -> grant order 0,1,0,1; each ready is a single pulse; no ready while busy.
- rst asserted in SH_DATA cycle 7 -> all outputs 0 asynchronously; no done; after release the same pending request is regranted from SH_ADDR.
- req0_valid deasserted, req1 valid alone twice -> req1 granted both times.
